// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU control unit: FSM states, instruction
// fields, ALU operation codes and datapath mux-select codes.
package cpu_pkg;

  typedef enum logic [6:0] {
    S_RESET      = 7'd0,
    S_FETCH      = 7'd1,
    S_DECODE     = 7'd2,
    S_EXEC_R     = 7'd3,
    S_WB_R       = 7'd4,
    S_ADDI       = 7'd5,
    S_WB_I       = 7'd6,
    S_LSADDR     = 7'd7,
    S_LW_RD      = 7'd8,
    S_LW_WB      = 7'd9,
    S_SW_WR      = 7'd10,
    S_JUMP       = 7'd11,
    S_JAL        = 7'd12,
    S_JR         = 7'd13,
    S_LUI        = 7'd14,
    S_BEQ        = 7'd15,
    S_BNE        = 7'd16,
    S_MULT_START = 7'd17,
    S_MULT_WAIT  = 7'd18,
    S_EXC_OP     = 7'd19,
    S_EXC_OVF    = 7'd20,
    S_EXC_RD_OP  = 7'd21,
    S_EXC_RD_OVF = 7'd22,
    S_EXC_JMP    = 7'd23
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;

  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_CMP   = 3'b111;

  localparam logic [1:0] PCS_JUMP   = 2'b00;
  localparam logic [1:0] PCS_ALU    = 2'b01;
  localparam logic [1:0] PCS_EPC    = 2'b10;
  localparam logic [1:0] PCS_ALUOUT = 2'b11;

  localparam logic [2:0] IORD_PC     = 3'b001;
  localparam logic [2:0] IORD_253    = 3'b010;
  localparam logic [2:0] IORD_255    = 3'b100;
  localparam logic [2:0] IORD_ALUOUT = 3'b101;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_SP = 2'b10;
  localparam logic [1:0] DST_RA = 2'b11;

  localparam logic [3:0] M2R_ALUOUT = 4'b0000;
  localparam logic [3:0] M2R_MDR    = 4'b0001;
  localparam logic [3:0] M2R_LUI    = 4'b0110;
  localparam logic [3:0] M2R_PC     = 4'b0111;
  localparam logic [3:0] M2R_227    = 4'b1000;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_A  = 2'b10;

  localparam logic [2:0] SRCB_B     = 3'b000;
  localparam logic [2:0] SRCB_4     = 3'b001;
  localparam logic [2:0] SRCB_SEXT2 = 3'b011;
  localparam logic [2:0] SRCB_SEXT  = 3'b100;

  // Only the signed arithmetic R-type ops can raise an overflow trap; 'and' cannot.
  function automatic logic traps_ovf(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB);
  endfunction

  function automatic state_e dispatch(input logic [5:0] op, input logic [5:0] fn);
    state_e nxt;
    nxt = S_EXC_OP;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND: nxt = S_EXEC_R;
          FN_JR:                  nxt = S_JR;
          FN_MULT:                nxt = S_MULT_START;
          default:                nxt = S_EXC_OP;
        endcase
      end
      OP_ADDI:        nxt = S_ADDI;
      OP_LW, OP_SW:   nxt = S_LSADDR;
      OP_J:           nxt = S_JUMP;
      OP_JAL:         nxt = S_JAL;
      OP_LUI:         nxt = S_LUI;
      OP_BEQ:         nxt = S_BEQ;
      OP_BNE:         nxt = S_BNE;
      default:        nxt = S_EXC_OP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/unid_controle.sv
// Multicycle CPU control unit: Moore FSM decoding datapath controls from state,
// with branch PCWrite and the multiply-done HiLoWrite following their flag inputs.
module unid_controle
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] ControlOp,
  input  logic [5:0] funct,
  input  logic       Overflow,
  input  logic       Zero,
  input  logic       MultEnd,
  output logic       PCWrite,
  output logic       ALUorMem,
  output logic [1:0] PCSource,
  output logic [2:0] IorD,
  output logic       MemWR,
  output logic       IRWrite,
  output logic       WrMDR,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [3:0] MemToReg,
  output logic       ABWrite,
  output logic [1:0] AluSrcA,
  output logic [2:0] AluSrcB,
  output logic [2:0] ALUOp,
  output logic       ALURegWrite,
  output logic       EPCWrite,
  output logic       StartMult,
  output logic       HiLoWrite,
  output logic [6:0] CurState
);

  localparam logic [7:0] CNT_LAST = 8'(MEM_WAIT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cnt_last_s;

  assign cnt_last_s = (cnt_q == CNT_LAST);

  // State and memory-wait counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and output decode; outputs are gated low while reset is held.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    PCWrite     = 1'b0;
    ALUorMem    = 1'b0;
    PCSource    = 2'b00;
    IorD        = 3'b000;
    MemWR       = 1'b0;
    IRWrite     = 1'b0;
    WrMDR       = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemToReg    = 4'b0000;
    ABWrite     = 1'b0;
    AluSrcA     = 2'b00;
    AluSrcB     = 3'b000;
    ALUOp       = 3'b000;
    ALURegWrite = 1'b0;
    EPCWrite    = 1'b0;
    StartMult   = 1'b0;
    HiLoWrite   = 1'b0;
    CurState    = 7'd0;

    if (!reset) begin
      state_d = S_RESET;
      cnt_d   = 8'd0;
    end else begin
      CurState = state_q;
      case (state_q)
        S_RESET: begin
          RegWrite = 1'b1;
          RegDst   = DST_SP;
          MemToReg = M2R_227;
          state_d  = S_FETCH;
        end
        S_FETCH: begin
          IorD = IORD_PC;
          if (cnt_last_s) begin
            cnt_d    = 8'd0;
            IRWrite  = 1'b1;
            AluSrcA  = SRCA_PC;
            AluSrcB  = SRCB_4;
            ALUOp    = ALU_ADD;
            PCSource = PCS_ALU;
            PCWrite  = 1'b1;
            state_d  = S_DECODE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_DECODE: begin
          ABWrite     = 1'b1;
          AluSrcA     = SRCA_PC;
          AluSrcB     = SRCB_SEXT2;
          ALUOp       = ALU_ADD;
          ALURegWrite = 1'b1;
          state_d     = dispatch(ControlOp, funct);
        end
        S_EXEC_R: begin
          AluSrcA     = SRCA_A;
          AluSrcB     = SRCB_B;
          ALURegWrite = 1'b1;
          case (funct)
            FN_SUB:  ALUOp = ALU_SUB;
            FN_AND:  ALUOp = ALU_AND;
            default: ALUOp = ALU_ADD;
          endcase
          state_d = (Overflow && traps_ovf(funct)) ? S_EXC_OVF : S_WB_R;
        end
        S_WB_R: begin
          RegWrite = 1'b1;
          RegDst   = DST_RD;
          MemToReg = M2R_ALUOUT;
          state_d  = S_FETCH;
        end
        S_ADDI, S_LSADDR: begin
          AluSrcA     = SRCA_A;
          AluSrcB     = SRCB_SEXT;
          ALUOp       = ALU_ADD;
          ALURegWrite = 1'b1;
          if (state_q == S_ADDI) begin
            state_d = Overflow ? S_EXC_OVF : S_WB_I;
          end else begin
            state_d = (ControlOp == OP_LW) ? S_LW_RD : S_SW_WR;
          end
        end
        S_WB_I: begin
          RegWrite = 1'b1;
          RegDst   = DST_RT;
          MemToReg = M2R_ALUOUT;
          state_d  = S_FETCH;
        end
        S_LW_RD: begin
          IorD = IORD_ALUOUT;
          if (cnt_last_s) begin
            cnt_d   = 8'd0;
            WrMDR   = 1'b1;
            state_d = S_LW_WB;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_LW_WB: begin
          RegWrite = 1'b1;
          RegDst   = DST_RT;
          MemToReg = M2R_MDR;
          state_d  = S_FETCH;
        end
        S_SW_WR: begin
          IorD    = IORD_ALUOUT;
          MemWR   = 1'b1;
          state_d = S_FETCH;
        end
        S_JUMP, S_JAL: begin
          PCSource = PCS_JUMP;
          PCWrite  = 1'b1;
          if (state_q == S_JAL) begin
            RegWrite = 1'b1;
            RegDst   = DST_RA;
            MemToReg = M2R_PC;
          end else begin
            RegWrite = 1'b0;
          end
          state_d = S_FETCH;
        end
        S_JR: begin
          AluSrcA  = SRCA_A;
          ALUOp    = ALU_PASSA;
          PCSource = PCS_ALU;
          PCWrite  = 1'b1;
          state_d  = S_FETCH;
        end
        S_LUI: begin
          RegWrite = 1'b1;
          RegDst   = DST_RT;
          MemToReg = M2R_LUI;
          state_d  = S_FETCH;
        end
        S_BEQ, S_BNE: begin
          AluSrcA  = SRCA_A;
          AluSrcB  = SRCB_B;
          ALUOp    = ALU_CMP;
          PCSource = PCS_ALUOUT;
          PCWrite  = (state_q == S_BEQ) ? Zero : !Zero;
          state_d  = S_FETCH;
        end
        S_MULT_START: begin
          StartMult = 1'b1;
          state_d   = S_MULT_WAIT;
        end
        S_MULT_WAIT: begin
          if (MultEnd) begin
            HiLoWrite = 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_MULT_WAIT;
          end
        end
        S_EXC_OP, S_EXC_OVF: begin
          // EPC <= PC - 4 undoes the increment made during fetch.
          EPCWrite = 1'b1;
          AluSrcA  = SRCA_PC;
          AluSrcB  = SRCB_4;
          ALUOp    = ALU_SUB;
          state_d  = (state_q == S_EXC_OP) ? S_EXC_RD_OP : S_EXC_RD_OVF;
        end
        S_EXC_RD_OP, S_EXC_RD_OVF: begin
          IorD = (state_q == S_EXC_RD_OP) ? IORD_253 : IORD_255;
          if (cnt_last_s) begin
            cnt_d   = 8'd0;
            WrMDR   = 1'b1;
            state_d = S_EXC_JMP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_EXC_JMP: begin
          ALUorMem = 1'b1;
          PCWrite  = 1'b1;
          state_d  = S_FETCH;
        end
        default: begin
          state_d = S_RESET;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unid_controle.sv
// Self-checking bench for unid_controle: an instruction-level model emits the expected
// control word for every cycle, and a negedge process compares the DUT against it.
module tb_unid_controle;

  localparam int MW = 2;

  typedef struct packed {
    logic       pcw;
    logic       aom;
    logic [1:0] pcs;
    logic [2:0] iord;
    logic       memwr;
    logic       irw;
    logic       wrmdr;
    logic       rw;
    logic [1:0] dst;
    logic [3:0] m2r;
    logic       abw;
    logic [1:0] srca;
    logic [2:0] srcb;
    logic [2:0] aluop;
    logic       alurw;
    logic       epcw;
    logic       smult;
    logic       hilo;
  } out_t;

  typedef struct packed {
    logic [7:0] id;
    logic [5:0] op;
    logic [5:0] fn;
    logic       zr;
    logic       ov;
    logic       me;
    out_t       e;
  } entry_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] ControlOp = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       Overflow = 1'b0;
  logic       Zero = 1'b0;
  logic       MultEnd = 1'b0;
  logic       PCWrite, ALUorMem, MemWR, IRWrite, WrMDR, RegWrite, ABWrite;
  logic       ALURegWrite, EPCWrite, StartMult, HiLoWrite;
  logic [1:0] PCSource, RegDst, AluSrcA;
  logic [2:0] IorD, AluSrcB, ALUOp;
  logic [3:0] MemToReg;
  logic [6:0] CurState;
  out_t       act;

  unid_controle #(.MEM_WAIT(MW)) dut (
    .clock(clock), .reset(reset), .ControlOp(ControlOp), .funct(funct),
    .Overflow(Overflow), .Zero(Zero), .MultEnd(MultEnd),
    .PCWrite(PCWrite), .ALUorMem(ALUorMem), .PCSource(PCSource), .IorD(IorD),
    .MemWR(MemWR), .IRWrite(IRWrite), .WrMDR(WrMDR), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .ABWrite(ABWrite), .AluSrcA(AluSrcA),
    .AluSrcB(AluSrcB), .ALUOp(ALUOp), .ALURegWrite(ALURegWrite),
    .EPCWrite(EPCWrite), .StartMult(StartMult), .HiLoWrite(HiLoWrite),
    .CurState(CurState)
  );

  assign act = {PCWrite, ALUorMem, PCSource, IorD, MemWR, IRWrite, WrMDR, RegWrite,
                RegDst, MemToReg, ABWrite, AluSrcA, AluSrcB, ALUOp, ALURegWrite,
                EPCWrite, StartMult, HiLoWrite};

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wb_cycle = 0;
  int rw_cnt = 0, epc_cnt = 0, sm_cnt = 0, hl_cnt = 0, hl_me_cnt = 0;

  entry_t plan_q[$];
  entry_t exp_q[$];

  logic [7:0] cur_id;
  logic [5:0] cur_op, cur_fn;
  logic       cur_zr, cur_ov;

  // Per-cycle comparison against the model plus event tallies for the pinned checks.
  always @(negedge clock) begin
    entry_t x;
    if (!reset) begin
      cyc = 0;
    end else begin
      cyc = cyc + 1;
      if (RegWrite) rw_cnt = rw_cnt + 1;
      if (EPCWrite) epc_cnt = epc_cnt + 1;
      if (StartMult) sm_cnt = sm_cnt + 1;
      if (HiLoWrite) hl_cnt = hl_cnt + 1;
      if (HiLoWrite && MultEnd) hl_me_cnt = hl_me_cnt + 1;
      if (RegWrite && RegDst == 2'b01 && wb_cycle == 0) wb_cycle = cyc;
    end
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      n_cmp = n_cmp + 1;
      if (act !== x.e) begin
        n_bad = n_bad + 1;
        $display("FAIL ctl_word instr=%0d cyc=%0d got=%h want=%h", x.id, cyc, act, x.e);
      end
    end
  end

  task automatic pin(input string name, input int actual, input int want);
    n_cmp = n_cmp + 1;
    if (actual != want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%0d want=%0d", name, actual, want);
    end
  endtask

  function automatic out_t nop();
    out_t o;
    o = '0;
    return o;
  endfunction

  task automatic push(input out_t o, input logic me);
    entry_t x;
    x.id = cur_id; x.op = cur_op; x.fn = cur_fn;
    x.zr = cur_zr; x.ov = cur_ov; x.me = me; x.e = o;
    plan_q.push_back(x);
  endtask

  task automatic m_init();
    out_t o;
    o = nop(); o.rw = 1'b1; o.dst = 2'b10; o.m2r = 4'b1000;
    push(o, 1'b0);
  endtask

  // Memory read of MW cycles at a fixed address, MDR loaded on the last one.
  task automatic m_read(input logic [2:0] addr);
    out_t o;
    for (int i = 0; i < MW; i++) begin
      o = nop(); o.iord = addr; o.wrmdr = (i == MW - 1);
      push(o, 1'b0);
    end
  endtask

  task automatic m_exc(input logic [2:0] addr);
    out_t o;
    o = nop(); o.epcw = 1'b1; o.srcb = 3'b001; o.aluop = 3'b010;
    push(o, 1'b0);
    m_read(addr);
    o = nop(); o.aom = 1'b1; o.pcw = 1'b1;
    push(o, 1'b0);
  endtask

  task automatic m_alu(input logic [2:0] srcb, input logic [2:0] aop);
    out_t o;
    o = nop(); o.srca = 2'b10; o.srcb = srcb; o.aluop = aop; o.alurw = 1'b1;
    push(o, 1'b0);
  endtask

  task automatic m_wb(input logic [1:0] dst, input logic [3:0] m2r);
    out_t o;
    o = nop(); o.rw = 1'b1; o.dst = dst; o.m2r = m2r;
    push(o, 1'b0);
  endtask

  // One instruction: fetch, decode, then the behaviour its opcode/funct call for.
  task automatic m_instr(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                         input logic ov, input int mend_at);
    out_t o;
    cur_id = cur_id + 8'd1; cur_op = op; cur_fn = fn; cur_zr = zr; cur_ov = ov;
    for (int i = 0; i < MW; i++) begin
      o = nop(); o.iord = 3'b001;
      if (i == MW - 1) begin
        o.irw = 1'b1; o.srcb = 3'b001; o.aluop = 3'b001; o.pcs = 2'b01; o.pcw = 1'b1;
      end
      push(o, 1'b0);
    end
    o = nop(); o.abw = 1'b1; o.srcb = 3'b011; o.aluop = 3'b001; o.alurw = 1'b1;
    push(o, (op == 6'h00 && fn == 6'h18));
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      m_alu(3'b000, (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011);
      if (ov && fn != 6'h24) m_exc(3'b100);
      else m_wb(2'b01, 4'b0000);
    end else if (op == 6'h00 && fn == 6'h08) begin
      o = nop(); o.srca = 2'b10; o.pcs = 2'b01; o.pcw = 1'b1;
      push(o, 1'b0);
    end else if (op == 6'h00 && fn == 6'h18) begin
      o = nop(); o.smult = 1'b1;
      push(o, 1'b1);
      if (mend_at == 0) begin
        for (int k = 0; k < 5; k++) push(nop(), 1'b0);
      end else begin
        for (int k = 1; k <= mend_at; k++) begin
          o = nop(); o.hilo = (k == mend_at);
          push(o, (k == mend_at));
        end
      end
    end else if (op == 6'h08) begin
      m_alu(3'b100, 3'b001);
      if (ov) m_exc(3'b100);
      else m_wb(2'b00, 4'b0000);
    end else if (op == 6'h23 || op == 6'h2b) begin
      m_alu(3'b100, 3'b001);
      if (op == 6'h23) begin
        m_read(3'b101);
        m_wb(2'b00, 4'b0001);
      end else begin
        o = nop(); o.iord = 3'b101; o.memwr = 1'b1;
        push(o, 1'b0);
      end
    end else if (op == 6'h02 || op == 6'h03) begin
      o = nop(); o.pcw = 1'b1;
      if (op == 6'h03) begin
        o.rw = 1'b1; o.dst = 2'b11; o.m2r = 4'b0111;
      end
      push(o, 1'b0);
    end else if (op == 6'h0f) begin
      m_wb(2'b00, 4'b0110);
    end else if (op == 6'h04 || op == 6'h05) begin
      o = nop(); o.srca = 2'b10; o.aluop = 3'b111; o.pcs = 2'b11;
      o.pcw = (op == 6'h04) ? zr : !zr;
      push(o, 1'b0);
    end else begin
      m_exc(3'b010);
    end
  endtask

  // Drives each planned cycle's inputs just after the rising edge and queues its expectation.
  task automatic play();
    entry_t x;
    while (plan_q.size() != 0) begin
      x = plan_q.pop_front();
      ControlOp = x.op; funct = x.fn; Zero = x.zr; Overflow = x.ov; MultEnd = x.me;
      exp_q.push_back(x);
      @(posedge clock);
      #1;
    end
    MultEnd = 1'b0;
  endtask

  initial begin
    int rw0, epc0, sm0, hl0, hlme0;
    cur_id = 8'd0; cur_op = 6'd0; cur_fn = 6'd0; cur_zr = 1'b0; cur_ov = 1'b0;

    repeat (3) @(posedge clock);
    #2;
    pin("reset_outputs", int'(act), 0);
    pin("reset_curstate", int'(CurState), 0);

    @(posedge clock); #1;
    reset = 1'b1;
    m_init();
    m_instr(6'h00, 6'h20, 1'b0, 1'b0, 0);
    play();
    pin("add_wb_cycle", wb_cycle, 6);

    rw0 = rw_cnt; epc0 = epc_cnt;
    m_instr(6'h00, 6'h20, 1'b0, 1'b1, 0);
    play();
    pin("ovf_no_regwrite", rw_cnt - rw0, 0);
    pin("ovf_epcwrite", epc_cnt - epc0, 1);

    m_instr(6'h00, 6'h22, 1'b0, 1'b0, 0);
    m_instr(6'h00, 6'h22, 1'b0, 1'b1, 0);
    m_instr(6'h00, 6'h24, 1'b0, 1'b1, 0);
    m_instr(6'h08, 6'h00, 1'b0, 1'b0, 0);
    m_instr(6'h08, 6'h00, 1'b0, 1'b1, 0);
    m_instr(6'h23, 6'h00, 1'b0, 1'b0, 0);
    m_instr(6'h2b, 6'h00, 1'b0, 1'b0, 0);
    m_instr(6'h02, 6'h00, 1'b0, 1'b0, 0);
    m_instr(6'h03, 6'h00, 1'b0, 1'b0, 0);
    m_instr(6'h00, 6'h08, 1'b0, 1'b0, 0);
    m_instr(6'h0f, 6'h00, 1'b0, 1'b0, 0);
    m_instr(6'h04, 6'h00, 1'b1, 1'b0, 0);
    m_instr(6'h04, 6'h00, 1'b0, 1'b0, 0);
    m_instr(6'h05, 6'h00, 1'b0, 1'b0, 0);
    m_instr(6'h05, 6'h00, 1'b1, 1'b0, 0);
    play();

    sm0 = sm_cnt; hl0 = hl_cnt; hlme0 = hl_me_cnt;
    m_instr(6'h00, 6'h18, 1'b0, 1'b0, 32);
    play();
    pin("mult_start_pulses", sm_cnt - sm0, 1);
    pin("mult_hilo_pulses", hl_cnt - hl0, 1);
    pin("mult_hilo_with_end", hl_me_cnt - hlme0, 1);

    epc0 = epc_cnt;
    m_instr(6'h3f, 6'h00, 1'b0, 1'b0, 0);
    m_instr(6'h00, 6'h01, 1'b0, 1'b0, 0);
    play();
    pin("badop_epcwrite", epc_cnt - epc0, 2);

    m_instr(6'h00, 6'h18, 1'b0, 1'b0, 0);
    play();
    #2;
    reset = 1'b0;
    #1;
    pin("async_reset_outputs", int'(act), 0);
    pin("async_reset_curstate", int'(CurState), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    m_init();
    m_instr(6'h0f, 6'h00, 1'b0, 1'b0, 0);
    play();

    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
